sprite_blitter: RTL and testbench

//  Writer side of the sprite-ROM / palette-index pixel path: copies a WxH rectangle of 4-bit colour

---
 rtl/blit_pkg.sv | 34 +++
 rtl/blit_addr_gen.sv | 70 +++++++
 rtl/sprite_blitter.sv | 121 ++++++++++++
 tb/tb_sprite_blitter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared types and constants for the sprite blitter: FSM state encoding, screen geometry,
// latched-request record and the frame-buffer address helper.
package blit_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned ROM_AW   = 18;
  localparam int unsigned FB_AW    = 19;
  localparam int unsigned IDX_W    = 4;

  localparam logic [IDX_W-1:0] TRANSP_IDX = '0;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DRAIN,
    DONE
  } blit_state_t;

  typedef struct packed {
    logic [ROM_AW-1:0] src;
    logic [9:0]        w;
    logic [9:0]        h;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              flip;
  } blit_cfg_t;

  // 11-bit coordinates in, row-major address out; the product is truncated to FB_AW.
  function automatic logic [FB_AW-1:0] fb_addr_f(input logic [10:0] x, input logic [10:0] y);
    return FB_AW'(21'(y) * 21'(SCREEN_W) + 21'(x));
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Raster col/row counters for the blitter, plus sprite-ROM address, destination address,
// on-screen qualification and last-pixel flag for the current pixel.
module blit_addr_gen
  import blit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic [ROM_AW-1:0] src_base_i,
  input  logic [9:0]        size_x_i,
  input  logic [9:0]        size_y_i,
  input  logic [9:0]        dst_x_i,
  input  logic [9:0]        dst_y_i,
  input  logic              flip_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic [FB_AW-1:0]  fb_addr_o,
  output logic              in_bounds_o,
  output logic              last_o
);

  logic [9:0]        col_q, col_d;
  logic [9:0]        row_q, row_d;
  logic              col_last;
  logic [9:0]        rom_col;
  logic [ROM_AW-1:0] row_off;
  logic [10:0]       x_sum;
  logic [10:0]       y_sum;

  assign col_last = (col_q == size_x_i - 10'd1);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (step_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign last_o = col_last && (row_q == size_y_i - 10'd1);

  // Mirroring only changes which ROM column is fetched; destination order is untouched.
  assign rom_col    = flip_i ? (size_x_i - 10'd1 - col_q) : col_q;
  assign row_off    = ROM_AW'({10'd0, row_q} * {10'd0, size_x_i});
  assign rom_addr_o = src_base_i + row_off + ROM_AW'(rom_col);

  assign x_sum       = {1'b0, dst_x_i} + {1'b0, col_q};
  assign y_sum       = {1'b0, dst_y_i} + {1'b0, row_q};
  assign in_bounds_o = (x_sum < 11'(SCREEN_W)) && (y_sum < 11'(SCREEN_H));
  assign fb_addr_o   = fb_addr_f(x_sum, y_sum);

endmodule

// File: rtl/sprite_blitter.sv
// Copies a WxH sprite from the synchronous sprite ROM into the index frame buffer, one pixel
// per clock, skipping transparent indices and clipping at the screen edge. MIRROR_EN adds flip_x.
module sprite_blitter
  import blit_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] src_base,
  input  logic [9:0]        size_x,
  input  logic [9:0]        size_y,
  input  logic [9:0]        dst_x,
  input  logic [9:0]        dst_y,
`ifdef MIRROR_EN
  input  logic              flip_x,
`endif
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [IDX_W-1:0]  fb_data
);

  blit_state_t state_q, state_d;
  blit_cfg_t   cfg_q, cfg_d;
  logic        accept;
  logic        last_pix;
  logic        cur_in_bounds;
  logic [FB_AW-1:0] cur_fb_addr;

  // Delay stage lining the destination up with ROM data that arrives one cycle later.
  logic             pipe_valid_q, pipe_valid_d;
  logic             pipe_inb_q, pipe_inb_d;
  logic [FB_AW-1:0] pipe_addr_q, pipe_addr_d;

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    cfg_d = cfg_q;
    if (accept) begin
      cfg_d.src = src_base;
      cfg_d.w   = size_x;
      cfg_d.h   = size_y;
      cfg_d.x   = dst_x;
      cfg_d.y   = dst_y;
`ifdef MIRROR_EN
      cfg_d.flip = flip_x;
`else
      cfg_d.flip = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ((size_x == '0) || (size_y == '0)) ? DONE : COPY;
        end
      end
      COPY:    if (last_pix) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pipe_valid_d = 1'b0;
    pipe_inb_d   = pipe_inb_q;
    pipe_addr_d  = pipe_addr_q;
    if (state_q == COPY) begin
      pipe_valid_d = 1'b1;
      pipe_inb_d   = cur_in_bounds;
      pipe_addr_d  = cur_fb_addr;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      pipe_valid_q <= 1'b0;
      pipe_inb_q   <= 1'b0;
      pipe_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_inb_q   <= pipe_inb_d;
      pipe_addr_q  <= pipe_addr_d;
    end
  end

  blit_addr_gen u_addr_gen (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .clear_i     (accept),
    .step_i      (state_q == COPY),
    .src_base_i  (cfg_q.src),
    .size_x_i    (cfg_q.w),
    .size_y_i    (cfg_q.h),
    .dst_x_i     (cfg_q.x),
    .dst_y_i     (cfg_q.y),
    .flip_i      (cfg_q.flip),
    .rom_addr_o  (rom_addr),
    .fb_addr_o   (cur_fb_addr),
    .in_bounds_o (cur_in_bounds),
    .last_o      (last_pix)
  );

  assign busy    = (state_q == COPY) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign fb_we   = pipe_valid_q && pipe_inb_q && (rom_data != TRANSP_IDX);
  assign fb_addr = pipe_addr_q;
  assign fb_data = pipe_valid_q ? rom_data : '0;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a vector table of copies plus hand-written reset,
// zero-size back-to-back and mirror sequences. Works with or without MIRROR_EN.
module tb_sprite_blitter;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic [17:0] src_base;
  logic [9:0]  size_x, size_y, dst_x, dst_y;
  logic        flip_x;
  logic        busy, done, fb_we;
  logic [17:0] rom_addr;
  logic [3:0]  rom_data;
  logic [18:0] fb_addr;
  logic [3:0]  fb_data;

  logic [3:0]  rom_mem [0:1023];

  int n_tests;
  int n_fail;

  // Results of the most recent run_copy.
  int wr_addr[$];
  int wr_data[$];
  int rd_addr[$];
  int done_cyc, n_done, busy_cnt, we_after_rst, busy_after_rst;

  sprite_blitter dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .src_base (src_base),
    .size_x   (size_x),
    .size_y   (size_y),
    .dst_x    (dst_x),
    .dst_y    (dst_y),
`ifdef MIRROR_EN
    .flip_x   (flip_x),
`endif
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) rom_data <= rom_mem[rom_addr[9:0]];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1; cycle 0 is the cycle in which start is high.
  task automatic run_copy(input logic [17:0] src, input logic [9:0] w, input logic [9:0] h,
                          input logic [9:0] x, input logic [9:0] y, input logic flip,
                          input int rst_cyc, input int ncyc, input int sp0, input int sp1);
    wr_addr.delete(); wr_data.delete(); rd_addr.delete();
    done_cyc = -1; n_done = 0; busy_cnt = 0; we_after_rst = 0; busy_after_rst = 0;
    start = 1'b1; src_base = src; size_x = w; size_y = h; dst_x = x; dst_y = y; flip_x = flip;
    for (int c = 0; c < ncyc; c++) begin
      if (c == rst_cyc) Reset = 1'b1;
      @(negedge Clk);
      if (rst_cyc >= 0 && c > rst_cyc) begin
        if (fb_we) we_after_rst++;
        if (busy) busy_after_rst++;
      end
      if (fb_we) begin
        wr_addr.push_back(int'(fb_addr));
        wr_data.push_back(int'(fb_data));
      end
      if (c >= 1 && c <= int'(w) * int'(h)) rd_addr.push_back(int'(rom_addr));
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy) busy_cnt++;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      // Scrambled inputs must not disturb a latched request.
      start = (c + 1 == sp0) || (c + 1 == sp1);
      src_base = ~src; size_x = 10'd1; size_y = 10'd1; dst_x = 10'd3; dst_y = 10'd3;
      flip_x = ~flip;
    end
    start = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [17:0] src;
    logic [9:0]  w, h, x, y;
    int          hole0, hole1;
    int          exp_n, exp_first, exp_last, exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int wh, nmis, ndat, hn, ha;
    int exp_addr[$];
    int exp_rd[$];
    n_tests = 0; n_fail = 0;
    Reset = 1'b1; start = 1'b0; src_base = '0; size_x = '0; size_y = '0;
    dst_x = '0; dst_y = '0; flip_x = 1'b0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 4'd5;

    vecs[0] = '{"basic",  18'd100, 10'd4, 10'd2, 10'd10,  10'd20,  -1,  -1, 8, 12810,  13453,  10};
    vecs[1] = '{"transp", 18'd100, 10'd4, 10'd2, 10'd10,  10'd20,  101, 106, 6, 12810, 13453, 10};
    vecs[2] = '{"clip",   18'd100, 10'd4, 10'd2, 10'd638, 10'd479, -1,  -1, 2, 307198, 307199, 10};
    vecs[3] = '{"offscr", 18'd100, 10'd2, 10'd2, 10'd700, 10'd10,  -1,  -1, 0, 0,      0,      6};
    vecs[4] = '{"one",    18'd0,   10'd1, 10'd1, 10'd0,   10'd0,   -1,  -1, 1, 0,      0,      3};
    vecs[5] = '{"h0",     18'd100, 10'd5, 10'd0, 10'd0,   10'd0,   -1,  -1, 0, 0,      0,      1};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset fb_we", int'(fb_we), 0);
    check("reset rom_addr", int'(rom_addr), 0);
    check("reset fb_addr", int'(fb_addr), 0);
    check("reset fb_data", int'(fb_data), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;

    foreach (vecs[i]) begin
      for (int k = 0; k < 1024; k++) rom_mem[k] = 4'd5;
      if (vecs[i].hole0 >= 0) rom_mem[vecs[i].hole0] = 4'd0;
      if (vecs[i].hole1 >= 0) rom_mem[vecs[i].hole1] = 4'd0;
      wh = int'(vecs[i].w) * int'(vecs[i].h);
      exp_addr.delete(); exp_rd.delete();
      for (int r = 0; r < int'(vecs[i].h); r++) begin
        for (int c = 0; c < int'(vecs[i].w); c++) begin
          ha = int'(vecs[i].src) + r * int'(vecs[i].w) + c;
          exp_rd.push_back(ha);
          if (int'(vecs[i].x) + c < 640 && int'(vecs[i].y) + r < 480 && rom_mem[ha] != 4'd0)
            exp_addr.push_back((int'(vecs[i].y) + r) * 640 + int'(vecs[i].x) + c);
        end
      end
      run_copy(vecs[i].src, vecs[i].w, vecs[i].h, vecs[i].x, vecs[i].y, 1'b0, -1,
               vecs[i].exp_done + 4, (wh >= 4) ? 4 : -1, vecs[i].exp_done);
      check({vecs[i].name, " writes"}, wr_addr.size(), vecs[i].exp_n);
      check({vecs[i].name, " done cycle"}, done_cyc, vecs[i].exp_done);
      check({vecs[i].name, " done pulses"}, n_done, 1);
      check({vecs[i].name, " busy cycles"}, busy_cnt, (wh == 0) ? 0 : wh + 1);
      if (wr_addr.size() > 0 && vecs[i].exp_n > 0) begin
        check({vecs[i].name, " first addr"}, wr_addr[0], vecs[i].exp_first);
        check({vecs[i].name, " last addr"}, wr_addr[wr_addr.size()-1], vecs[i].exp_last);
      end
      nmis = 0; ndat = 0;
      hn = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
      for (int k = 0; k < hn; k++) begin
        if (wr_addr[k] != exp_addr[k]) nmis++;
        if (wr_data[k] != 5) ndat++;
      end
      check({vecs[i].name, " addr list errors"}, nmis, 0);
      check({vecs[i].name, " data errors"}, ndat, 0);
      nmis = 0;
      for (int k = 0; k < rd_addr.size() && k < exp_rd.size(); k++)
        if (rd_addr[k] != exp_rd[k]) nmis++;
      check({vecs[i].name, " rom_addr errors"}, nmis, 0);
    end
    for (int k = 0; k < 1024; k++) rom_mem[k] = 4'd5;

    // Zero width, then a 1x1 request in the cycle right after done.
    run_copy(18'd100, 10'd0, 10'd7, 10'd0, 10'd0, 1'b0, -1, 2, -1, -1);
    check("w0 done cycle", done_cyc, 1);
    check("w0 busy cycles", busy_cnt, 0);
    check("w0 writes", wr_addr.size(), 0);
    run_copy(18'd100, 10'd1, 10'd1, 10'd5, 10'd5, 1'b0, -1, 6, -1, -1);
    check("b2b done cycle", done_cyc, 3);
    check("b2b writes", wr_addr.size(), 1);
    if (wr_addr.size() > 0) check("b2b addr", wr_addr[0], 3205);

    // Reset during cycle 3 of a 4x2 copy, then a full copy.
    run_copy(18'd100, 10'd4, 10'd2, 10'd10, 10'd20, 1'b0, 3, 12, -1, -1);
    check("rst writes before", wr_addr.size(), 2);
    check("rst fb_we after", we_after_rst, 0);
    check("rst busy after", busy_after_rst, 0);
    check("rst done pulses", n_done, 0);
    run_copy(18'd100, 10'd4, 10'd2, 10'd10, 10'd20, 1'b0, -1, 12, -1, -1);
    check("post-rst writes", wr_addr.size(), 8);
    check("post-rst done cycle", done_cyc, 10);

    // Mirror: ROM row {1,2,3}.
    rom_mem[200] = 4'd1; rom_mem[201] = 4'd2; rom_mem[202] = 4'd3;
    run_copy(18'd200, 10'd3, 10'd1, 10'd0, 10'd0, 1'b1, -1, 8, -1, -1);
    check("mirror writes", wr_data.size(), 3);
    if (wr_data.size() == 3) begin
`ifdef MIRROR_EN
      check("mirror data0", wr_data[0], 3);
      check("mirror data1", wr_data[1], 2);
      check("mirror data2", wr_data[2], 1);
`else
      check("mirror data0", wr_data[0], 1);
      check("mirror data1", wr_data[1], 2);
      check("mirror data2", wr_data[2], 3);
`endif
      check("mirror addr2", wr_addr[2], 2);
    end
    check("mirror done cycle", done_cyc, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
